// File: rtl/imem_fetch_ctrl_if.sv
// Bus bundle for the instruction-fetch controller: loader word stream,
// instruction-memory write port, fetch PC, redirect inputs and status.
// The master modport is the controller side, the slave modport the surroundings.
interface imem_fetch_ctrl_if #(
  parameter int AW = 5
);
  // Loader word stream
  logic          ld_valid_i;
  logic          ld_ready_o;
  logic [31:0]   ld_data_i;
  logic          ld_last_i;
  // Instruction memory write port
  logic          mem_we_o;
  logic [AW-1:0] mem_waddr_o;
  logic [31:0]   mem_wdata_o;
  // Fetch address and redirect
  logic [31:0]   pc_o;
  logic          pc_valid_o;
  logic          stall_i;
  logic          branch_i;
  logic [31:0]   branch_target_i;
  // Status
  logic [AW:0]   prog_len_o;
  logic [31:0]   fetch_cnt_o;
  logic          done_o;
  logic          err_o;

  modport master (
    input  ld_valid_i, ld_data_i, ld_last_i,
    output ld_ready_o,
    output mem_we_o, mem_waddr_o, mem_wdata_o,
    output pc_o, pc_valid_o,
    input  stall_i, branch_i, branch_target_i,
    output prog_len_o, fetch_cnt_o, done_o, err_o
  );

  modport slave (
    output ld_valid_i, ld_data_i, ld_last_i,
    input  ld_ready_o,
    input  mem_we_o, mem_waddr_o, mem_wdata_o,
    input  pc_o, pc_valid_o,
    output stall_i, branch_i, branch_target_i,
    input  prog_len_o, fetch_cnt_o, done_o, err_o
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch controller. Loads a program into the instruction memory
// from a valid/ready word stream, then steps the fetch PC through it,
// honouring stalls and branch redirects, until end of program or an illegal
// redirect. DONE and ERR are sticky until reset.
module imem_fetch_ctrl #(
  parameter int          MEM_WORDS = 32,
  parameter int          AW        = 5,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic              clk_i,
  input  logic              rst_i,
  imem_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {
    S_LOAD,
    S_RUN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state;
  logic [AW-1:0] wr_cnt;
  logic [AW:0]   prog_len;
  logic [31:0]   pc;
  logic [31:0]   fetch_cnt;
  logic          done;
  logic          err;

  logic          accept;
  logic          wr_full;
  logic [31:0]   limit;
  logic [31:0]   pc_plus4;
  logic          tgt_bad;

  // Fetch counter never wraps; it sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Byte limit of the loaded program, used for end-of-program and redirect checks.
  function automatic logic [31:0] byte_limit(input logic [AW:0] words);
    logic [31:0] w;
    w = 32'(words);
    return w << 2;
  endfunction

  assign accept   = bus.ld_valid_i && (state == S_LOAD);
  assign wr_full  = (wr_cnt == AW'(MEM_WORDS - 1));
  assign limit    = byte_limit(prog_len);
  assign pc_plus4 = pc + 32'd4;
  assign tgt_bad  = (bus.branch_target_i[1:0] != 2'b00) || (bus.branch_target_i >= limit);

  assign bus.ld_ready_o  = (state == S_LOAD);
  assign bus.mem_we_o    = accept;
  assign bus.mem_waddr_o = wr_cnt;
  assign bus.mem_wdata_o = bus.ld_data_i;
  assign bus.pc_valid_o  = (state == S_RUN);
  assign bus.pc_o        = pc;
  assign bus.prog_len_o  = prog_len;
  assign bus.fetch_cnt_o = fetch_cnt;
  assign bus.done_o      = done;
  assign bus.err_o       = err;

  // Load / run / terminal-state sequencer with registered status outputs.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state     <= S_LOAD;
      wr_cnt    <= '0;
      prog_len  <= '0;
      pc        <= RESET_PC;
      fetch_cnt <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      case (state)
        S_LOAD: begin
          if (accept) begin
            wr_cnt <= wr_cnt + AW'(1);
            // A full memory ends the load even without ld_last.
            if (bus.ld_last_i || wr_full) begin
              prog_len <= (AW+1)'(wr_cnt) + (AW+1)'(1);
              pc       <= RESET_PC;
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (bus.branch_i) begin
            // Redirect takes priority over stall.
            if (tgt_bad) begin
              err   <= 1'b1;
              state <= S_ERR;
            end else begin
              pc        <= bus.branch_target_i;
              fetch_cnt <= sat_inc(fetch_cnt);
            end
          end else if (!bus.stall_i) begin
            fetch_cnt <= sat_inc(fetch_cnt);
            if (pc_plus4 >= limit) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        S_DONE: begin
          state <= S_DONE;
        end
        S_ERR: begin
          state <= S_ERR;
        end
        default: begin
          state <= S_LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: load, sequential fetch, stall, branch
// priority, illegal redirects and asynchronous reset during load.
module tb_imem_fetch_ctrl;

  localparam int AW = 5;

  logic clk_i;
  logic rst_i;
  int   n_checks;
  int   n_errors;

  imem_fetch_ctrl_if #(.AW(AW)) bus ();

  imem_fetch_ctrl #(
    .MEM_WORDS (32),
    .AW        (AW),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .bus   (bus.master)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ld_valid_i      = 1'b0;
    bus.ld_data_i       = 32'h0;
    bus.ld_last_i       = 1'b0;
    bus.stall_i         = 1'b0;
    bus.branch_i        = 1'b0;
    bus.branch_target_i = 32'h0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, 32'(bus.ld_ready_o), 32'd1);
    check({tag, "_pcv"},   32'(bus.pc_valid_o), 32'd0);
    check({tag, "_len"},   32'(bus.prog_len_o), 32'd0);
    check({tag, "_pc"},    bus.pc_o,            32'd0);
    check({tag, "_cnt"},   bus.fetch_cnt_o,     32'd0);
    check({tag, "_done"},  32'(bus.done_o),     32'd0);
    check({tag, "_err"},   32'(bus.err_o),      32'd0);
  endtask

  // Stream n words; ld_last accompanies the final word when use_last is set.
  task automatic load_words(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      bus.ld_valid_i = 1'b1;
      bus.ld_data_i  = 32'hC0DE_0000 + 32'(i);
      bus.ld_last_i  = use_last && (i == n - 1);
      #1;
      check("ld_we",    32'(bus.mem_we_o),    32'd1);
      check("ld_waddr", 32'(bus.mem_waddr_o), 32'(i));
      check("ld_wdata", bus.mem_wdata_o,      32'hC0DE_0000 + 32'(i));
      tick();
    end
    bus.ld_valid_i = 1'b0;
    bus.ld_last_i  = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    idle_inputs();
    rst_i = 1'b1;
    #2;
    do_reset();
    check_reset_state("rst");
    check("rst_we_idle", 32'(bus.mem_we_o), 32'd0);

    // 4-word program, free-running fetch to DONE.
    load_words(4, 1'b1);
    check("t1_len",   32'(bus.prog_len_o), 32'd4);
    check("t1_ready", 32'(bus.ld_ready_o), 32'd0);
    check("t1_pcv",   32'(bus.pc_valid_o), 32'd1);
    check("t1_pc0",   bus.pc_o,            32'd0);
    tick();
    check("t1_pc4",   bus.pc_o,            32'd4);
    tick();
    check("t1_pc8",   bus.pc_o,            32'd8);
    tick();
    check("t1_pc12",  bus.pc_o,            32'd12);
    check("t1_cnt3",  bus.fetch_cnt_o,     32'd3);
    check("t1_nodone", 32'(bus.done_o),    32'd0);
    tick();
    check("t1_done",  32'(bus.done_o),     32'd1);
    check("t1_pcvd",  32'(bus.pc_valid_o), 32'd0);
    check("t1_pchold", bus.pc_o,           32'd12);
    check("t1_cnt4",  bus.fetch_cnt_o,     32'd4);
    tick();
    check("t1_sticky", 32'(bus.done_o),    32'd1);

    // Full memory without ld_last.
    do_reset();
    load_words(32, 1'b0);
    check("t2_len",   32'(bus.prog_len_o), 32'd32);
    check("t2_ready", 32'(bus.ld_ready_o), 32'd0);
    check("t2_pcv",   32'(bus.pc_valid_o), 32'd1);
    check("t2_pc0",   bus.pc_o,            32'd0);

    // 8-word program: stall at pc 8, then branch beats stall.
    do_reset();
    check("t3_cnt_clr", bus.fetch_cnt_o, 32'd0);
    load_words(8, 1'b1);
    check("t3_len", 32'(bus.prog_len_o), 32'd8);
    tick();
    tick();
    check("t3_pc8", bus.pc_o, 32'd8);
    check("t3_cnt2", bus.fetch_cnt_o, 32'd2);
    bus.stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("t3_stall_pc",  bus.pc_o,        32'd8);
      check("t3_stall_cnt", bus.fetch_cnt_o, 32'd2);
    end
    bus.stall_i = 1'b0;
    tick();
    check("t4_pc12", bus.pc_o, 32'd12);
    check("t4_cnt3", bus.fetch_cnt_o, 32'd3);
    bus.stall_i         = 1'b1;
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'd4;
    tick();
    check("t4_br_pc",  bus.pc_o,        32'd4);
    check("t4_br_cnt", bus.fetch_cnt_o, 32'd4);
    check("t4_br_pcv", 32'(bus.pc_valid_o), 32'd1);

    // Out-of-range redirect at pc 4.
    bus.stall_i         = 1'b0;
    bus.branch_target_i = 32'd32;
    tick();
    check("t5a_err",  32'(bus.err_o),      32'd1);
    check("t5a_pcv",  32'(bus.pc_valid_o), 32'd0);
    check("t5a_pc",   bus.pc_o,            32'd4);
    check("t5a_cnt",  bus.fetch_cnt_o,     32'd4);
    bus.branch_target_i = 32'd8;
    tick();
    check("t5a_hold", bus.pc_o,            32'd4);
    check("t5a_sticky", 32'(bus.err_o),    32'd1);

    // Misaligned redirect.
    do_reset();
    check_reset_state("t5_rst");
    load_words(8, 1'b1);
    tick();
    check("t5b_pc4", bus.pc_o, 32'd4);
    bus.branch_i        = 1'b1;
    bus.branch_target_i = 32'd6;
    tick();
    check("t5b_err",  32'(bus.err_o),      32'd1);
    check("t5b_pcv",  32'(bus.pc_valid_o), 32'd0);
    check("t5b_pc",   bus.pc_o,            32'd4);
    check("t5b_done", 32'(bus.done_o),     32'd0);

    // Asynchronous reset after 2 of 5 words.
    do_reset();
    load_words(2, 1'b0);
    bus.ld_valid_i = 1'b1;
    bus.ld_data_i  = 32'hDEAD_0002;
    #1;
    check("t6_waddr2", 32'(bus.mem_waddr_o), 32'd2);
    #2;
    rst_i = 1'b0;
    #1;
    check_reset_state("t6_async");
    check("t6_waddr0", 32'(bus.mem_waddr_o), 32'd0);
    bus.ld_valid_i = 1'b0;
    tick();
    rst_i = 1'b1;
    load_words(5, 1'b1);
    check("t6_len", 32'(bus.prog_len_o), 32'd5);
    check("t6_pcv", 32'(bus.pc_valid_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
